// File: rtl/load_store_unit_pkg.sv
// Shared widths, memory request/response encodings and LSU state encoding for the
// load/store unit and the writeback stage that reuses load_extend.
package load_store_unit_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned MEM_COUNT_W = 2;
  localparam int unsigned MEM_CODE_W  = 3;
  localparam int unsigned LSU_STATE_W = 2;
  localparam int unsigned LSU_CNT_W   = 4;

  typedef enum logic [MEM_COUNT_W-1:0] {
    MemCountNone = 2'd0,
    MemCountByte = 2'd1,
    MemCountHalf = 2'd2,
    MemCountWord = 2'd3
  } mem_count_e;

  typedef enum logic [MEM_CODE_W-1:0] {
    MemCodeRead        = 3'd0,
    MemCodeWrite       = 3'd1,
    MemCodeMisaligned  = 3'd2,
    MemCodeOutOfBounds = 3'd3,
    MemCodeInvalid     = 3'd4
  } mem_code_e;

  typedef enum logic [LSU_STATE_W-1:0] {
    LsuIdle = 2'd0,
    LsuReq  = 2'd1,
    LsuWait = 2'd2,
    LsuResp = 2'd3
  } lsu_state_e;

  function automatic logic mem_code_is_err(mem_code_e code);
    return (code == MemCodeMisaligned) || (code == MemCodeOutOfBounds) ||
           (code == MemCodeInvalid);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Upstream request, downstream result and memory request/response bundle of the LSU.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [WORD_W-1:0] i_wr_data;
  logic              i_wr_en;
  mem_count_e        i_count;
  logic              i_unsigned;

  logic              o_valid;
  logic              i_ready;
  logic [WORD_W-1:0] o_rd_data;
  mem_code_e         o_code;
  logic              o_exc;

  logic [ADDR_W-1:0] o_req_addr;
  logic [WORD_W-1:0] o_req_wr_data;
  logic              o_req_wr_en;
  mem_count_e        o_req_count;
  logic [WORD_W-1:0] i_res_rd_data;
  mem_code_e         i_res_code;

  // The unit itself.
  modport slave (
    input  i_valid, i_addr, i_wr_data, i_wr_en, i_count, i_unsigned, i_ready,
    input  i_res_rd_data, i_res_code,
    output o_ready, o_valid, o_rd_data, o_code, o_exc,
    output o_req_addr, o_req_wr_data, o_req_wr_en, o_req_count
  );

  // Pipeline plus memory surrounding the unit.
  modport master (
    output i_valid, i_addr, i_wr_data, i_wr_en, i_count, i_unsigned, i_ready,
    output i_res_rd_data, i_res_code,
    input  o_ready, o_valid, o_rd_data, o_code, o_exc,
    input  o_req_addr, o_req_wr_data, o_req_wr_en, o_req_count
  );

endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of right-aligned load data; shared with the writeback stage.
module load_extend
  import load_store_unit_pkg::*;
(
  input  mem_count_e        count,
  input  logic              zero_ext,
  input  logic [WORD_W-1:0] raw,
  output logic [WORD_W-1:0] ext
);

  always_comb begin
    ext = raw;
    unique case (count)
      MemCountByte: ext = {{(WORD_W-8){~zero_ext & raw[7]}}, raw[7:0]};
      MemCountHalf: ext = {{(WORD_W-16){~zero_ext & raw[15]}}, raw[15:0]};
      default:      ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage sequencer: one load/store at a time, single-cycle memory request, fixed
// response latency, extended result held until the writeback stage consumes it.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned RESP_LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  localparam logic [LSU_CNT_W-1:0] CntLast = LSU_CNT_W'(RESP_LATENCY - 1);

  lsu_state_e            state_q, state_d;
  logic [LSU_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  zero_ext_q, zero_ext_d;
  mem_count_e            count_q, count_d;
  logic [WORD_W-1:0]     rd_data_q, rd_data_d;
  mem_code_e             code_q, code_d;
  logic                  exc_q, exc_d;
  logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
  logic [WORD_W-1:0]     req_wr_data_q, req_wr_data_d;
  logic                  req_wr_en_q, req_wr_en_d;
  mem_count_e            req_count_q, req_count_d;
  logic [WORD_W-1:0]     ext_data;

  load_extend u_load_extend (
    .count    (count_q),
    .zero_ext (zero_ext_q),
    .raw      (bus.i_res_rd_data),
    .ext      (ext_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_en_d       = wr_en_q;
    zero_ext_d    = zero_ext_q;
    count_d       = count_q;
    rd_data_d     = rd_data_q;
    code_d        = code_q;
    exc_d         = exc_q;
    req_addr_d    = req_addr_q;
    req_wr_data_d = req_wr_data_q;
    req_wr_en_d   = req_wr_en_q;
    req_count_d   = req_count_q;

    unique case (state_q)
      LsuIdle: begin
        if (bus.i_valid) begin
          if (bus.i_count == MemCountNone) begin
            // Nothing to transfer: answer locally without touching memory.
            code_d    = MemCodeInvalid;
            exc_d     = 1'b1;
            rd_data_d = '0;
            state_d   = LsuResp;
          end else begin
            wr_en_d       = bus.i_wr_en;
            count_d       = bus.i_count;
            zero_ext_d    = bus.i_unsigned;
            req_addr_d    = bus.i_addr;
            req_wr_data_d = bus.i_wr_data;
            req_wr_en_d   = bus.i_wr_en;
            req_count_d   = bus.i_count;
            state_d       = LsuReq;
          end
        end
      end
      LsuReq: begin
        req_count_d = MemCountNone;
        req_wr_en_d = 1'b0;
        cnt_d       = '0;
        state_d     = LsuWait;
      end
      LsuWait: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CntLast) begin
          code_d    = bus.i_res_code;
          exc_d     = mem_code_is_err(bus.i_res_code);
          rd_data_d = (!wr_en_q && bus.i_res_code == MemCodeRead) ? ext_data : '0;
          state_d   = LsuResp;
        end
      end
      LsuResp: begin
        if (bus.i_ready) begin
          state_d = LsuIdle;
        end
      end
      default: state_d = LsuIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LsuIdle;
      cnt_q         <= '0;
      wr_en_q       <= 1'b0;
      zero_ext_q    <= 1'b0;
      count_q       <= MemCountNone;
      rd_data_q     <= '0;
      code_q        <= MemCodeInvalid;
      exc_q         <= 1'b0;
      req_addr_q    <= '0;
      req_wr_data_q <= '0;
      req_wr_en_q   <= 1'b0;
      req_count_q   <= MemCountNone;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_en_q       <= wr_en_d;
      zero_ext_q    <= zero_ext_d;
      count_q       <= count_d;
      rd_data_q     <= rd_data_d;
      code_q        <= code_d;
      exc_q         <= exc_d;
      req_addr_q    <= req_addr_d;
      req_wr_data_q <= req_wr_data_d;
      req_wr_en_q   <= req_wr_en_d;
      req_count_q   <= req_count_d;
    end
  end

  assign bus.o_ready       = (state_q == LsuIdle);
  assign bus.o_valid       = (state_q == LsuResp);
  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_code        = code_q;
  assign bus.o_exc         = exc_q;
  assign bus.o_req_addr    = req_addr_q;
  assign bus.o_req_wr_data = req_wr_data_q;
  assign bus.o_req_wr_en   = req_wr_en_q;
  assign bus.o_req_count   = req_count_q;

endmodule
